// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads instruction memory, and queues {instr, pc} for decode.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirect targets raise a sticky fetch_fault that stops fetching.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        fetch_fault
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   count_q, count_d;
  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   pc_mem_q    [DEPTH];
  logic          pop, push, fault_stop;

  // Without the check, the low two bits of a redirect target are dropped.
  function automatic logic [31:0] redirect_target(input logic [31:0] t);
`ifdef FETCH_ALIGN_CHECK_EN
    return t;
`else
    return t & 32'hFFFF_FFFC;
`endif
  endfunction

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q, fault_d;

  always_comb begin
    fault_d = fault_q;
    if (redirect_valid && (redirect_pc[1:0] != 2'b00)) fault_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) fault_q <= 1'b0;
    else     fault_q <= fault_d;
  end

  assign fault_stop  = fault_q;
  assign fetch_fault = fault_q;
`else
  assign fault_stop  = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  assign imem_addr = pc_q;
  assign id_valid  = (count_q != '0);
  assign id_instr  = id_valid ? instr_mem_q[head_q] : 32'h0;
  assign id_pc     = id_valid ? pc_mem_q[head_q]    : 32'h0;

  assign pop  = id_valid & id_ready;
  assign push = ~redirect_valid & ~fault_stop & ((count_q < DEPTH_C) | pop);

  always_comb begin
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (redirect_valid) begin
      pc_d    = redirect_target(redirect_pc);
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop)  head_d = head_q + 1'b1;
      if (push) begin
        tail_d = tail_q + 1'b1;
        pc_d   = pc_q + 32'd4;
      end
      count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Queue storage carries data only; validity comes from count_q.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      instr_mem_q[tail_q] <= imem_instr;
      pc_mem_q[tail_q]    <= pc_q;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: queue-level reference model checked every cycle plus directed literal checks.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        fetch_fault;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h13;
  endfunction

  assign imem_instr = mem(imem_addr);

  instruction_fetch #(.RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
    .id_pc(id_pc), .fetch_fault(fetch_fault)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of fetched PCs, the fetch PC, and the fault flag.
  logic [31:0] mq[$];
  logic [31:0] mpc;
  logic        mfault;
  bit          model_ok = 0;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      mpc      = 32'h0;
      mfault   = 1'b0;
      model_ok = 1;
    end else if (redirect_valid) begin
      mq.delete();
`ifdef FETCH_ALIGN_CHECK_EN
      if (redirect_pc[1:0] != 2'b00) mfault = 1'b1;
      mpc = redirect_pc;
`else
      mpc = {redirect_pc[31:2], 2'b00};
`endif
    end else begin
      if (mq.size() != 0 && id_ready) void'(mq.pop_front());
      if (!mfault && mq.size() < 2) begin
        mq.push_back(mpc);
        mpc = mpc + 32'd4;
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("m_valid", {31'b0, id_valid}, {31'b0, mq.size() != 0});
      chk("m_pc",    id_pc,    (mq.size() != 0) ? mq[0] : 32'h0);
      chk("m_instr", id_instr, (mq.size() != 0) ? mem(mq[0]) : 32'h0);
      chk("m_addr",  imem_addr, mpc);
      chk("m_fault", {31'b0, fetch_fault}, {31'b0, mfault});
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    cyc();
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    @(negedge clk);
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
    cyc();
    chk("first_valid", {31'b0, id_valid}, 32'd1);
    chk("first_pc",    id_pc, 32'h0);
    chk("first_instr", id_instr, 32'h13);
    chk("first_addr",  imem_addr, 32'h4);

    // Streaming
    id_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("stream_pc", id_pc, 32'(4 * i));
      cyc();
    end

    // Backpressure from pc=0
    id_ready = 1'b0;
    redirect(32'h0);
    cyc(); cyc(); cyc();
    chk("bp_addr",  imem_addr, 32'h8);
    chk("bp_pc",    id_pc, 32'h0);
    cyc();
    chk("bp_hold_addr", imem_addr, 32'h8);
    chk("bp_hold_pc",   id_pc, 32'h0);
    id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_drain_pc", id_pc, 32'(4 * i));
      cyc();
    end

    // Redirect with two entries queued
    id_ready = 1'b0;
    cyc();
    redirect(32'h40);
    chk("redir_valid", {31'b0, id_valid}, 32'd0);
    chk("redir_addr",  imem_addr, 32'h40);
    cyc();
    chk("redir_pc",    id_pc, 32'h40);
    chk("redir_instr", id_instr, mem(32'h40));

    // PC wrap
    id_ready = 1'b1;
    redirect(32'hFFFF_FFFC);
    cyc();
    chk("wrap_pc0", id_pc, 32'hFFFF_FFFC);
    cyc();
    chk("wrap_pc1", id_pc, 32'h0);

    // Back-to-back redirects: last wins
    redirect_valid = 1'b1; redirect_pc = 32'h100; cyc();
    redirect_pc = 32'h200; cyc();
    redirect_valid = 1'b0;
    chk("b2b_addr", imem_addr, 32'h200);
    cyc();
    chk("b2b_pc", id_pc, 32'h200);

    // Reset beats a simultaneous redirect
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h300;
    cyc();
    rst = 1'b0; redirect_valid = 1'b0;
    chk("rst_redir_addr",  imem_addr, 32'h0);
    chk("rst_redir_valid", {31'b0, id_valid}, 32'd0);
    cyc();

    // Misaligned redirect
    redirect(32'h42);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("align_fault", {31'b0, fetch_fault}, 32'd1);
    chk("align_addr",  imem_addr, 32'h42);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("align_stall_valid", {31'b0, id_valid}, 32'd0);
    end
    redirect(32'h80);
    chk("align_sticky", {31'b0, fetch_fault}, 32'd1);
    cyc();
    chk("align_sticky_valid", {31'b0, id_valid}, 32'd0);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("align_rst_fault", {31'b0, fetch_fault}, 32'd0);
    cyc();
    chk("align_rst_valid", {31'b0, id_valid}, 32'd1);
`else
    chk("align_addr", imem_addr, 32'h40);
    cyc();
    chk("align_pc",    id_pc, 32'h40);
    chk("align_fault", {31'b0, fetch_fault}, 32'd0);
`endif
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
